inst_fetch: RTL and testbench

Instruction fetch front end: the reader on the address/data/exception interface of `inst_memory`. It owns the program counter and drives `mem_addr` every cycle. It captures `mem_data`/`mem_exc` one cycle later and hands instructions to decode through a valid/ready handshake backed by a 2-entry skid buffer. It sustains one instruction per cycle, accepts branch redirects, and halts cleanly on a memory address exception.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/fetch_skid_buffer.sv | 53 +++++
 rtl/inst_fetch.sv | 102 ++++++++++
 tb/tb_inst_fetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, fetch FSM states and buffer entry type
package cpu_pkg;

    localparam int DEF_ADDR_WIDTH = 16;
    localparam int DEF_DATA_WIDTH = 16;

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] inst;
        logic [DEF_ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// rtl/fetch_skid_buffer.sv - 2-entry in-order skid buffer of fetched instructions
module fetch_skid_buffer
    import cpu_pkg::*;
(
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_flush,
    input  logic         i_push,
    input  fetch_entry_t i_push_entry,
    input  logic         i_pop,
    output logic         o_head_valid,
    output fetch_entry_t o_head_entry,
    output logic [1:0]   o_count
);

    logic [1:0]   r_count;
    fetch_entry_t r_ent0;
    fetch_entry_t r_ent1;

    logic         w_pop;
    logic [1:0]   w_wr_slot;

    assign w_pop     = i_pop & (r_count != 2'd0);
    // Slot the new entry lands in once this cycle's pop has shifted the queue.
    assign w_wr_slot = r_count - {1'b0, w_pop};

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_count <= 2'd0;
            r_ent0  <= '0;
            r_ent1  <= '0;
        end else if (i_flush) begin
            r_count <= 2'd0;
        end else begin
            if (w_pop) begin
                r_ent0 <= r_ent1;
            end
            if (i_push) begin
                if (w_wr_slot == 2'd0) begin
                    r_ent0 <= i_push_entry;
                end else begin
                    r_ent1 <= i_push_entry;
                end
            end
            r_count <= r_count + {1'b0, i_push} - {1'b0, w_pop};
        end
    end

    assign o_head_valid = (r_count != 2'd0);
    assign o_head_entry = r_ent0;
    assign o_count      = r_count;

endmodule

// File: rtl/inst_fetch.sv
// rtl/inst_fetch.sv - instruction fetch front end: PC, one-deep memory pipeline,
// skid-buffered decode handshake, redirect and halt-on-fault.
module inst_fetch
    import cpu_pkg::*;
#(
    parameter int                    ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int                    DATA_WIDTH = DEF_DATA_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_data,
    input  logic                  mem_exc,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  inst_valid,
    output logic [DATA_WIDTH-1:0] inst,
    output logic [ADDR_WIDTH-1:0] inst_pc,
    input  logic                  inst_ready,
    output logic                  fetch_exc,
    output logic [ADDR_WIDTH-1:0] exc_pc
);

    logic [ADDR_WIDTH-1:0] r_pc;
    logic [ADDR_WIDTH-1:0] r_tag_pc;
    logic                  r_inflight;
    fetch_state_t          r_state;
    logic                  r_fetch_exc;
    logic [ADDR_WIDTH-1:0] r_exc_pc;

    logic                  w_pop;
    logic [1:0]            w_count;
    logic [2:0]            w_occ;
    logic [2:0]            w_limit;
    logic                  w_issue;
    logic                  w_resp_live;
    logic                  w_push;
    logic                  w_fault;
    fetch_entry_t          w_push_entry;
    fetch_entry_t          w_head;

    assign w_pop   = inst_valid & inst_ready;
    assign w_occ   = {1'b0, w_count} + {2'b00, r_inflight};
    assign w_limit = 3'd2 + {2'b00, w_pop};
    assign w_issue = (r_state == RUN) & ~redirect_valid & (w_occ < w_limit);

    // A response whose address was issued in the faulting cycle arrives in HALT
    // and is dropped, so exc_pc keeps the first faulting address.
    assign w_resp_live = r_inflight & (r_state == RUN) & ~redirect_valid;
    assign w_push      = w_resp_live & ~mem_exc;
    assign w_fault     = w_resp_live & mem_exc;

    assign w_push_entry.inst = mem_data;
    assign w_push_entry.pc   = r_tag_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc        <= RESET_PC;
            r_tag_pc    <= '0;
            r_inflight  <= 1'b0;
            r_state     <= RUN;
            r_fetch_exc <= 1'b0;
            r_exc_pc    <= '0;
        end else if (redirect_valid) begin
            r_pc        <= redirect_pc;
            r_inflight  <= 1'b0;
            r_state     <= RUN;
            r_fetch_exc <= 1'b0;
        end else begin
            r_inflight <= w_issue;
            if (w_issue) begin
                r_tag_pc <= r_pc;
                r_pc     <= r_pc + 1'b1;
            end
            if (w_fault) begin
                r_fetch_exc <= 1'b1;
                r_exc_pc    <= r_tag_pc;
                r_state     <= HALT;
            end
        end
    end

    fetch_skid_buffer u_buf (
        .clk          (clk),
        .i_rst        (rst),
        .i_flush      (redirect_valid),
        .i_push       (w_push),
        .i_push_entry (w_push_entry),
        .i_pop        (w_pop & ~redirect_valid),
        .o_head_valid (inst_valid),
        .o_head_entry (w_head),
        .o_count      (w_count)
    );

    assign mem_addr  = r_pc;
    assign inst      = w_head.inst;
    assign inst_pc   = w_head.pc;
    assign fetch_exc = r_fetch_exc;
    assign exc_pc    = r_exc_pc;

endmodule

// File: tb/tb_inst_fetch.sv
// tb/tb_inst_fetch.sv - scoreboard bench for inst_fetch with a 64-word registered memory
module tb_inst_fetch;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] mem_addr;
    logic [15:0] mem_data;
    logic        mem_exc;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        inst_valid;
    logic [15:0] inst;
    logic [15:0] inst_pc;
    logic        inst_ready;
    logic        fetch_exc;
    logic [15:0] exc_pc;

    int checks = 0;
    int errors = 0;
    fetch_entry_t exp_q[$];
    logic [15:0] mem [0:63];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        mem_exc  <= (mem_addr >= 16'd64);
        mem_data <= (mem_addr < 16'd64) ? mem[mem_addr[5:0]] : 16'h0000;
    end

    inst_fetch #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .RESET_PC(16'h0000)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_addr       (mem_addr),
        .mem_data       (mem_data),
        .mem_exc        (mem_exc),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_ready     (inst_ready),
        .fetch_exc      (fetch_exc),
        .exc_pc         (exc_pc)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        fetch_entry_t e;
        if (inst_valid && inst_ready && !redirect_valid && !rst) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_extra: got %h@%h, required no delivery", inst, inst_pc);
            end else begin
                e = exp_q.pop_front();
                if (inst !== e.inst || inst_pc !== e.pc) begin
                    errors++;
                    $display("FAIL scoreboard: got %h@%h, required %h@%h", inst, inst_pc, e.inst, e.pc);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic expect_inst(input logic [15:0] d, input logic [15:0] pc);
        fetch_entry_t e;
        e.inst = d;
        e.pc   = pc;
        exp_q.push_back(e);
    endtask

    task automatic do_redirect(input logic [15:0] pc);
        exp_q.delete();
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        step();
        redirect_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!inst_valid && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (!inst_valid) begin
            errors++;
            $display("FAIL %s_timeout: inst_valid=%b, required 1 within 20 cycles", name, inst_valid);
        end
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_undelivered: %0d entries left, required 0", name, exp_q.size());
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (mem_addr !== 16'h0000) begin errors++; $display("FAIL %s_mem_addr: got %h, required 0000", name, mem_addr); end
        checks++;
        if (inst_valid !== 1'b0) begin errors++; $display("FAIL %s_inst_valid: got %b, required 0", name, inst_valid); end
        checks++;
        if (inst !== 16'h0000) begin errors++; $display("FAIL %s_inst: got %h, required 0000", name, inst); end
        checks++;
        if (inst_pc !== 16'h0000) begin errors++; $display("FAIL %s_inst_pc: got %h, required 0000", name, inst_pc); end
        checks++;
        if (fetch_exc !== 1'b0) begin errors++; $display("FAIL %s_fetch_exc: got %b, required 0", name, fetch_exc); end
        checks++;
        if (exc_pc !== 16'h0000) begin errors++; $display("FAIL %s_exc_pc: got %h, required 0000", name, exc_pc); end
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 16'h0000;
        for (int i = 0; i < 3; i++) step();
        check_reset_outputs("reset");
    endtask

    task automatic test_streaming();
        inst_ready = 1'b1;
        expect_inst(16'h1111, 16'd0);
        expect_inst(16'h2222, 16'd1);
        expect_inst(16'h3333, 16'd2);
        expect_inst(16'h4444, 16'd3);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL stream_latency_c%0d: inst_valid=%b, required 0", i, inst_valid);
            end
            step();
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (inst_valid !== 1'b1) begin
                errors++;
                $display("FAIL stream_consecutive_%0d: inst_valid=%b, required 1", i, inst_valid);
            end
            step();
        end
        inst_ready = 1'b0;
        check_queue_empty("stream");
    endtask

    task automatic test_backpressure();
        logic [15:0] frozen;
        inst_ready = 1'b1;
        do_redirect(16'd0);
        expect_inst(16'h1111, 16'd0);
        checks++;
        if (mem_addr !== 16'd0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_r1: mem_addr=%h inst_valid=%b, required 0000 and 0", mem_addr, inst_valid);
        end
        step();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_r2: inst_valid=%b, required 0", inst_valid);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL redirect_r3: inst_valid=%b, required 1", inst_valid);
        end
        step();
        inst_ready = 1'b0;
        expect_inst(16'h2222, 16'd1);
        expect_inst(16'h3333, 16'd2);
        expect_inst(16'h4444, 16'd3);
        frozen = 16'hffff;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (inst_valid !== 1'b1 || inst !== 16'h2222 || inst_pc !== 16'd1) begin
                errors++;
                $display("FAIL stall_hold_%0d: got %b %h@%h, required 1 2222@0001", i, inst_valid, inst, inst_pc);
            end
            if (i == 1) frozen = mem_addr;
            if (i == 4) begin
                checks++;
                if (dut.u_buf.r_count !== 2'd2) begin
                    errors++;
                    $display("FAIL stall_count: got %0d, required 2", dut.u_buf.r_count);
                end
            end
            step();
        end
        checks++;
        if (mem_addr !== frozen) begin
            errors++;
            $display("FAIL stall_addr_frozen: got %h, required %h", mem_addr, frozen);
        end
        inst_ready = 1'b1;
        for (int i = 0; i < 3; i++) step();
        inst_ready = 1'b0;
        check_queue_empty("backpressure");
    endtask

    task automatic test_exception();
        logic [15:0] frozen;
        int n = 0;
        inst_ready = 1'b1;
        do_redirect(16'd62);
        expect_inst(16'h0000, 16'd62);
        expect_inst(16'h6464, 16'd63);
        while (!fetch_exc && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (fetch_exc !== 1'b1 || exc_pc !== 16'd64) begin
            errors++;
            $display("FAIL exc_raised: fetch_exc=%b exc_pc=%h, required 1 and 0040", fetch_exc, exc_pc);
        end
        check_queue_empty("exception");
        frozen = mem_addr;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (inst_valid !== 1'b0) begin
                errors++;
                $display("FAIL halt_no_valid_%0d: inst_valid=%b, required 0", i, inst_valid);
            end
            step();
        end
        checks++;
        if (mem_addr !== frozen || fetch_exc !== 1'b1 || exc_pc !== 16'd64) begin
            errors++;
            $display("FAIL halt_frozen: mem_addr=%h fetch_exc=%b exc_pc=%h, required %h 1 0040", mem_addr, fetch_exc, exc_pc, frozen);
        end
    endtask

    task automatic test_redirect_clears_halt();
        inst_ready = 1'b1;
        do_redirect(16'd0);
        expect_inst(16'h1111, 16'd0);
        checks++;
        if (fetch_exc !== 1'b0 || inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_halt_r1: fetch_exc=%b inst_valid=%b, required 0 0", fetch_exc, inst_valid);
        end
        step();
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++;
            $display("FAIL clear_halt_r2: inst_valid=%b, required 0", inst_valid);
        end
        step();
        checks++;
        if (inst_valid !== 1'b1) begin
            errors++;
            $display("FAIL clear_halt_r3: inst_valid=%b, required 1", inst_valid);
        end
        step();
        inst_ready = 1'b0;
        check_queue_empty("clear_halt");
    endtask

    task automatic test_redirect_vs_response();
        int n = 0;
        inst_ready = 1'b1;
        do_redirect(16'd62);
        expect_inst(16'h0000, 16'd62);
        while (mem_exc !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        checks++;
        if (mem_exc !== 1'b1) begin
            errors++;
            $display("FAIL vs_fault_seen: mem_exc=%b, required 1", mem_exc);
        end
        do_redirect(16'd2);
        expect_inst(16'h3333, 16'd2);
        checks++;
        if (fetch_exc !== 1'b0) begin
            errors++;
            $display("FAIL vs_fault_discarded: fetch_exc=%b, required 0", fetch_exc);
        end
        wait_valid("vs_fault");
        step();
        check_queue_empty("vs_fault");

        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) step();
        checks++;
        if (dut.u_buf.r_count !== 2'd2) begin
            errors++;
            $display("FAIL vs_full_count: got %0d, required 2", dut.u_buf.r_count);
        end
        inst_ready = 1'b1;
        do_redirect(16'd2);
        expect_inst(16'h3333, 16'd2);
        checks++;
        if (inst_valid !== 1'b0 || fetch_exc !== 1'b0) begin
            errors++;
            $display("FAIL vs_full_flushed: inst_valid=%b fetch_exc=%b, required 0 0", inst_valid, fetch_exc);
        end
        wait_valid("vs_full");
        step();
        inst_ready = 1'b0;
        check_queue_empty("vs_full");
    endtask

    task automatic test_reset_midstream();
        inst_ready = 1'b1;
        do_redirect(16'd0);
        expect_inst(16'h1111, 16'd0);
        step();
        step();
        checks++;
        if (dut.r_inflight !== 1'b1 || dut.u_buf.r_count !== 2'd1) begin
            errors++;
            $display("FAIL midreset_precond: inflight=%b count=%0d, required 1 and 1", dut.r_inflight, dut.u_buf.r_count);
        end
        exp_q.delete();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset_outputs("midreset");
        expect_inst(16'h1111, 16'd0);
        expect_inst(16'h2222, 16'd1);
        wait_valid("midreset");
        step();
        step();
        inst_ready = 1'b0;
        check_queue_empty("midreset");
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 16'h0000;
        mem[0]  = 16'h1111;
        mem[1]  = 16'h2222;
        mem[2]  = 16'h3333;
        mem[3]  = 16'h4444;
        mem[63] = 16'h6464;

        test_reset();
        test_streaming();
        test_backpressure();
        test_exception();
        test_redirect_clears_halt();
        test_redirect_vs_response();
        test_reset_midstream();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
